// File: rtl/keen_writeback_arbiter.sv
// Round-robin arbiter that funnels several register-file writeback requesters
// into a single registered write port, with a saturating contention counter.
module keen_writeback_arbiter #(
    parameter int REQUESTERS   = 2,
    parameter int WORD_SIZE    = 32,
    parameter int ADDRESS_SIZE = 5
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            hold,
    input  logic                            req_valids    [REQUESTERS],
    input  logic [ADDRESS_SIZE-1:0]         req_addresses [REQUESTERS],
    input  logic [WORD_SIZE-1:0]            req_data      [REQUESTERS],
    output logic                            req_readys    [REQUESTERS],
    output logic [ADDRESS_SIZE-1:0]         write_address,
    output logic [WORD_SIZE-1:0]            write_data,
    output logic                            write_enable,
    output logic [$clog2(REQUESTERS)-1:0]   grant_id,
    output logic [7:0]                      stall_count
);
    localparam int ID_W = $clog2(REQUESTERS);

    logic [ID_W-1:0]         ptr;
    logic [ID_W-1:0]         win;
    logic [ID_W-1:0]         ptr_next;
    logic                    found;
    logic                    grant;
    logic                    stall;
    int                      nvalid;
    int                      idx;

    logic                    vld_p1;
    logic [ADDRESS_SIZE-1:0] addr_p1;
    logic [WORD_SIZE-1:0]    data_p1;
    logic [ID_W-1:0]         gid_p1;
    logic [7:0]              stall_q;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Stage p0: pick the first valid requester at or after ptr; data never enters this path.
    always_comb begin
        found  = 1'b0;
        win    = '0;
        nvalid = 0;
        idx    = 0;
        for (int i = 0; i < REQUESTERS; i++) begin
            idx = (int'(ptr) + i) % REQUESTERS;
            if (!found && req_valids[idx]) begin
                found = 1'b1;
                win   = ID_W'(idx);
            end
            if (req_valids[i]) nvalid++;
        end
        grant    = found && !hold && !reset;
        stall    = nvalid > (grant ? 1 : 0);
        ptr_next = (win == ID_W'(REQUESTERS - 1)) ? '0 : win + 1'b1;
    end

    always_comb begin
        for (int k = 0; k < REQUESTERS; k++) begin
            req_readys[k] = grant && (win == ID_W'(k));
        end
    end

    // Stage p1: registered write port; address 0 is consumed but never strobed.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr     <= '0;
            vld_p1  <= 1'b0;
            addr_p1 <= '0;
            data_p1 <= '0;
            gid_p1  <= '0;
            stall_q <= '0;
        end else begin
            vld_p1 <= grant && (req_addresses[win] != '0);
            if (grant) begin
                addr_p1 <= req_addresses[win];
                data_p1 <= req_data[win];
                gid_p1  <= win;
                ptr     <= ptr_next;
            end
            if (stall) stall_q <= sat_inc(stall_q);
        end
    end

    // Outputs read zero for the whole reset cycle, so a write caught in the output stage is dropped.
    assign write_enable  = vld_p1 && !reset;
    assign write_address = reset ? '0 : addr_p1;
    assign write_data    = reset ? '0 : data_p1;
    assign grant_id      = reset ? '0 : gid_p1;
    assign stall_count   = reset ? '0 : stall_q;

endmodule

// File: tb/tb_keen_writeback_arbiter.sv
// Directed plus randomized bench for keen_writeback_arbiter against a cycle-level reference model.
module tb_keen_writeback_arbiter;
    localparam int R  = 2;
    localparam int WS = 32;
    localparam int AS = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          hold = 1'b0;
    logic          valids [R];
    logic [AS-1:0] addrs  [R];
    logic [WS-1:0] datas  [R];
    logic          readys [R];
    logic [AS-1:0] write_address;
    logic [WS-1:0] write_data;
    logic          write_enable;
    logic [0:0]    grant_id;
    logic [7:0]    stall_count;

    int tests = 0;
    int fails = 0;

    // reference model state
    int          m_ptr = 0;
    logic        m_we = 0;
    logic [AS-1:0] m_addr = 0;
    logic [WS-1:0] m_data = 0;
    int          m_gid = 0;
    int          m_stall = 0;

    keen_writeback_arbiter #(.REQUESTERS(R), .WORD_SIZE(WS), .ADDRESS_SIZE(AS)) dut (
        .clk(clk), .reset(reset), .hold(hold),
        .req_valids(valids), .req_addresses(addrs), .req_data(datas),
        .req_readys(readys), .write_address(write_address), .write_data(write_data),
        .write_enable(write_enable), .grant_id(grant_id), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Round-robin choice straight from the rule: first valid index searching upward from m_ptr.
    function automatic int pick();
        for (int i = 0; i < R; i++) begin
            if (valids[(m_ptr + i) % R]) return (m_ptr + i) % R;
        end
        return -1;
    endfunction

    task automatic cycle();
        int w;
        int nv;
        logic [R-1:0] obs_rdy;
        logic [R-1:0] exp_rdy;
        @(negedge clk);
        w = (reset || hold) ? -1 : pick();
        exp_rdy = '0;
        if (w >= 0) exp_rdy[w] = 1'b1;
        for (int k = 0; k < R; k++) obs_rdy[k] = readys[k];
        chk("ready", 64'(obs_rdy), 64'(exp_rdy));
        chk("we",    64'(write_enable),  reset ? 64'd0 : 64'(m_we));
        chk("addr",  64'(write_address), reset ? 64'd0 : 64'(m_addr));
        chk("data",  64'(write_data),    reset ? 64'd0 : 64'(m_data));
        chk("gid",   64'(grant_id),      reset ? 64'd0 : 64'(m_gid));
        chk("stall", 64'(stall_count),   reset ? 64'd0 : 64'(m_stall));
        nv = 0;
        for (int k = 0; k < R; k++) if (valids[k]) nv++;
        if (reset) begin
            m_ptr = 0; m_we = 0; m_addr = 0; m_data = 0; m_gid = 0; m_stall = 0;
        end else begin
            m_we = (w >= 0) && (addrs[w] != 0);
            if (w >= 0) begin
                m_addr = addrs[w];
                m_data = datas[w];
                m_gid  = w;
                m_ptr  = (w + 1) % R;
            end
            if (nv > ((w >= 0) ? 1 : 0) && m_stall < 255) m_stall++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic v, input logic [AS-1:0] a, input logic [WS-1:0] d);
        valids[k] = v;
        addrs[k]  = a;
        datas[k]  = d;
    endtask

    initial begin
        int s0;
        for (int k = 0; k < R; k++) set_req(k, 1'b0, '0, '0);
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;

        // two requesters, one write each
        set_req(0, 1'b1, 5'd3, 32'hA);
        set_req(1, 1'b1, 5'd4, 32'hB);
        cycle();
        chk("w1_we", 64'(write_enable), 64'd1);
        chk("w1_addr", 64'(write_address), 64'd3);
        chk("w1_data", 64'(write_data), 64'hA);
        chk("w1_gid", 64'(grant_id), 64'd0);
        valids[0] = 1'b0;
        cycle();
        chk("w2_addr", 64'(write_address), 64'd4);
        chk("w2_data", 64'(write_data), 64'hB);
        chk("w2_gid", 64'(grant_id), 64'd1);
        chk("w2_stall", 64'(stall_count), 64'd1);
        valids[1] = 1'b0;
        cycle();
        chk("idle_we", 64'(write_enable), 64'd0);
        chk("idle_hold_addr", 64'(write_address), 64'd4);

        // sustained alternation
        set_req(0, 1'b1, 5'd9, 32'h1111);
        set_req(1, 1'b1, 5'd9, 32'h2222);
        for (int i = 0; i < 10; i++) begin
            cycle();
            chk("alt_we", 64'(write_enable), 64'd1);
        end
        chk("same_addr_last", 64'(write_data), 64'h2222);
        set_req(0, 1'b0, '0, '0);
        set_req(1, 1'b0, '0, '0);
        cycle();

        // address 0 from requester 1: consumed, no strobe
        set_req(1, 1'b1, 5'd0, 32'h55);
        cycle();
        chk("a0_we", 64'(write_enable), 64'd0);
        chk("a0_data", 64'(write_data), 64'h55);
        set_req(0, 1'b1, 5'd2, 32'h20);
        set_req(1, 1'b1, 5'd3, 32'h30);
        cycle();
        chk("a0_next_gid", 64'(grant_id), 64'd0);

        // hold for 3 cycles
        s0 = m_stall;
        hold = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        chk("hold_stall", 64'(stall_count), 64'(s0 + 3));
        chk("hold_we", 64'(write_enable), 64'd0);

        // saturation
        for (int i = 0; i < 300; i++) cycle();
        chk("sat", 64'(stall_count), 64'd255);
        cycle();
        chk("sat_stay", 64'(stall_count), 64'd255);
        hold = 1'b0;
        set_req(0, 1'b0, '0, '0);
        set_req(1, 1'b0, '0, '0);
        cycle();

        // reset right after a transfer to address 7
        set_req(0, 1'b1, 5'd7, 32'h77);
        cycle();
        set_req(0, 1'b0, '0, '0);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        chk("rst_we", 64'(write_enable), 64'd0);
        chk("rst_addr", 64'(write_address), 64'd0);
        chk("rst_data", 64'(write_data), 64'd0);
        chk("rst_gid", 64'(grant_id), 64'd0);
        chk("rst_stall", 64'(stall_count), 64'd0);
        set_req(0, 1'b1, 5'd1, 32'h1);
        set_req(1, 1'b1, 5'd2, 32'h2);
        cycle();
        chk("rst_prio", 64'(grant_id), 64'd0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < R; k++) begin
                if (!valids[k] || readys[k]) begin
                    set_req(k, 1'($urandom_range(0, 2) != 0), AS'($urandom), $urandom);
                end
            end
            hold  = ($urandom_range(0, 7) == 0);
            reset = ($urandom_range(0, 49) == 0);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
